// File: rtl/conv_window_stream_pkg.sv
// Shared types and elaboration helpers for the streaming convolution window generator.
package conv_pkg;

    typedef enum logic [0:0] {RUN, FLUSH} conv_state_t;

    localparam int PIXEL_W = 16;
    typedef logic [PIXEL_W-1:0] pixel_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int pad_of(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_window_stream_line_buffer.sv
// One image row of delay: a DEPTH-word shift register advanced only on a window step.
module conv_line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= d_i;
            for (int d = 1; d < DEPTH; d++) begin
                mem_q[d] <= mem_q[d-1];
            end
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_stream.sv
// Zero-padded NxN sliding-window generator with stride filter, valid/ready flow control
// and an internal end-of-frame flush that pushes P*W+P zero pixels.
module conv_window_stream
    import conv_pkg::*;
#(
    parameter int N           = 3,
    parameter int BitSize     = 16,
    parameter int ImageWidth  = 8,
    parameter int ImageHeight = 8,
    parameter int Channels    = 1,
    parameter int Stride      = 1
) (
    input  logic                             clk,
    input  logic                             res_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Channels*BitSize-1:0]      in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [Channels*N*N*BitSize-1:0]  out_data,
    output logic                             out_done
);

    localparam int W       = ImageWidth;
    localparam int H       = ImageHeight;
    localparam int S       = Stride;
    localparam int P       = pad_of(N);
    localparam int PW      = Channels * BitSize;
    localparam int OW      = Channels * N * N * BitSize;
    localparam int K_TOTAL = H * W + P * W + P;
    localparam int KW      = $clog2(K_TOTAL) + 1;
    localparam int RW      = $clog2(H) + 1;
    localparam int CW      = $clog2(W) + 1;
    localparam int SW      = $clog2(S) + 1;

    localparam logic [KW-1:0] K_LAST    = KW'(K_TOTAL - 1);
    localparam logic [KW-1:0] K_IN_LAST = KW'(H * W - 1);
    localparam logic [KW-1:0] K_OFFS    = KW'(P * W + P);
    localparam logic [RW-1:0] R_DONE    = RW'((ceil_div(H, S) - 1) * S);
    localparam logic [CW-1:0] C_MAX     = CW'(W - 1);
    localparam logic [CW-1:0] C_DONE    = CW'((ceil_div(W, S) - 1) * S);
    localparam logic [SW-1:0] S_MAX     = SW'(S - 1);

    if (N % 2 == 0) begin : g_chk_n
        $error("conv_window_stream: N must be odd");
    end
    if (S < 1) begin : g_chk_s
        $error("conv_window_stream: Stride must be >= 1");
    end
    if (W < N || H < N) begin : g_chk_dim
        $error("conv_window_stream: image must be at least NxN");
    end

    conv_state_t      state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RW-1:0]    cr_q, cr_d;
    logic [CW-1:0]    cc_q, cc_d;
    logic [SW-1:0]    rs_q, rs_d, cs_q, cs_d;
    logic             out_valid_q, out_valid_d, out_done_q, out_done_d;
    logic [OW-1:0]    out_data_q, out_data_d, win_flat;
    logic             stall, step, centre_ok, emit, last_win;
    logic [PW-1:0]    tap_in [N];
    logic [PW-1:0]    win_q  [N][N];
    logic [PW-1:0]    win_nx [N][N];
    int               rr, cl;

    assign stall       = out_valid_q && !out_ready;
    assign in_ready    = res_n && (state_q == RUN) && !stall;
    assign step        = ((state_q == RUN) && in_valid && in_ready) || ((state_q == FLUSH) && !stall);
    assign tap_in[N-1] = (state_q == RUN) ? in_data : '0;
    assign centre_ok   = (k_q >= K_OFFS);
    assign emit        = step && centre_ok && (rs_q == '0) && (cs_q == '0);
    assign last_win    = (cr_q == R_DONE) && (cc_q == C_DONE);

    // Row taps: tap_in[i] is the pixel pushed (N-1-i) rows earlier.
    for (genvar l = 0; l < N - 1; l++) begin : g_lb
        conv_line_buffer #(.DEPTH(W), .WIDTH(PW)) u_lb (
            .clk  (clk),
            .en_i (step),
            .d_i  (tap_in[N-1-l]),
            .q_o  (tap_in[N-2-l])
        );
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j < N - 1) begin : g_shift
                assign win_nx[i][j] = win_q[i][j+1];
            end else begin : g_load
                assign win_nx[i][j] = tap_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step) begin
            win_q <= win_nx;
        end
    end

    // Raster taps wrap across rows and reach into stale rows; position-based masking zeroes them.
    always_comb begin
        win_flat = '0;
        rr       = 0;
        cl       = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                rr = int'(cr_q) + i - P;
                cl = int'(cc_q) + j - P;
                if (rr >= 0 && rr < H && cl >= 0 && cl < W) begin
                    for (int c = 0; c < Channels; c++) begin
                        win_flat[((c*N + i)*N + j)*BitSize +: BitSize] = win_nx[i][j][c*BitSize +: BitSize];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cr_d        = cr_q;
        cc_d        = cc_q;
        rs_d        = rs_q;
        cs_d        = cs_q;
        out_valid_d = out_valid_q;
        out_done_d  = out_done_q;
        out_data_d  = out_data_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_done_d  = 1'b0;
        end
        if (step) begin
            if (emit) begin
                out_valid_d = 1'b1;
                out_done_d  = last_win;
                out_data_d  = win_flat;
            end
            if (k_q == K_LAST) begin
                state_d = RUN;
                k_d     = '0;
                cr_d    = '0;
                cc_d    = '0;
                rs_d    = '0;
                cs_d    = '0;
            end else begin
                k_d = k_q + 1'b1;
                if (k_q == K_IN_LAST) begin
                    state_d = FLUSH;
                end
                if (centre_ok) begin
                    if (cc_q == C_MAX) begin
                        cc_d = '0;
                        cs_d = '0;
                        cr_d = cr_q + 1'b1;
                        rs_d = (rs_q == S_MAX) ? '0 : rs_q + 1'b1;
                    end else begin
                        cc_d = cc_q + 1'b1;
                        cs_d = (cs_q == S_MAX) ? '0 : cs_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= RUN;
            k_q         <= '0;
            cr_q        <= '0;
            cc_q        <= '0;
            rs_q        <= '0;
            cs_q        <= '0;
            out_valid_q <= 1'b0;
            out_done_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cr_q        <= cr_d;
            cc_q        <= cc_d;
            rs_q        <= rs_d;
            cs_q        <= cs_d;
            out_valid_q <= out_valid_d;
            out_done_q  <= out_done_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_done  = out_done_q;
    assign out_data  = out_data_q;

endmodule
